result_reducer: RTL and testbench
=================================

Name: result_reducer

Overview:
- Downstream consumer of the opcode ALU stage. Takes its Avalon-ST result packets: sop word = opcode header, following words = per-beat ALU results.
- Reduces each packet to a fixed 2-word summary packet: a header word (opcode + data-beat count), then the 32-bit wrapping sum of all result words.
- Applies backpressure upstream while a summary is pending. Counts framing errors.

Parameters:
- DATA_W, 32, stream data width. Sum width equals DATA_W.
- CNT_W, 16, beat-count width. Must be ≤ DATA_W-2. The count saturates at 2^CNT_W-1.
- ERR_W, 8, framing-error counter width. The counter saturates.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- snk_sop  in  1  Avalon-ST sink start of packet (ready_latency = 0).
- snk_eop  in  1  sink end of packet.
- snk_valid  in  1  sink valid.
- snk_data  in  DATA_W  sink data.
- snk_ready  out  1  sink ready.
- src_ready  in  1  Avalon-ST source ready (ready_latency = 0).
- src_sop  out  1  source start of packet.
- src_eop  out  1  source end of packet.
- src_valid  out  1  source valid.
- src_data  out  DATA_W  source data.
- err_count  out  ERR_W  saturating count of framing errors.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Handshakes:
  - Sink beat accepted ⇔ snk_valid & snk_ready.
  - Source beat transferred ⇔ src_valid & src_ready.
  - Beats with valid low are ignored.
- Reset:
  - FSM goes to IDLE; sum, count and opcode registers cleared.
  - src_valid/src_sop/src_eop = 0, src_data = 0, err_count = 0.
  - snk_ready = 0 while rst is high.
  - Reset in any state, including mid-packet or mid-emit, discards all partial or pending data. No output beat appears after it.
- FSM states: IDLE, ACCUM, EMIT_HDR, EMIT_SUM.
- snk_ready:
  - Decoded from state: 1 in IDLE and ACCUM, 0 in EMIT_HDR and EMIT_SUM.
  - No combinational path from src_ready.
- IDLE:
  - Accepted beat with sop=1 and eop=0: opcode ← data[1:0], sum ← 0, count ← 0, go to ACCUM.
  - Accepted beat with sop=1 and eop=1 (header-only packet): opcode latched, sum = 0, count = 0, go to EMIT_HDR.
  - Accepted beat with sop=0: dropped, err_count += 1, stay in IDLE.
- ACCUM:
  - Accepted beat with sop=0: sum ← sum + data (mod 2^DATA_W); count ← count+1, saturating.
  - If that beat has eop=1, it is included in sum and count, then go to EMIT_HDR.
  - Accepted beat with sop=1 (missing eop): err_count += 1. The partial packet is discarded and the new packet restarts exactly as sop in IDLE, including the sop&eop case.
- EMIT_HDR:
  - Outputs: src_valid=1, src_sop=1, src_eop=0.
  - src_data = {count (CNT_W bits), zeros, opcode (2 bits)}: count in bits [DATA_W-1:DATA_W-CNT_W], opcode in [1:0], all other bits 0.
  - All outputs held stable until src_ready. On transfer, go to EMIT_SUM.
- EMIT_SUM:
  - Outputs: src_valid=1, src_sop=0, src_eop=1, src_data = sum. Held until src_ready.
  - On transfer, go to IDLE.
- Outputs are registered.
- Latency:
  - eop accepted at edge t → header valid from t+1, at the earliest.
  - Header transferred at t+1 → sum valid at t+2.
  - Sum transferred at edge u → snk_ready = 1 from u+1.
- Minimum spacing: 4 cycles per 1-data-beat packet with src_ready held high.
- Error counter: increments at most once per cycle and saturates at 2^ERR_W-1.
- Opcode enum values ADD=0, XOR=1, AND=2, OR=3 are carried through unchanged. No opcode-dependent arithmetic is performed.

Decomposition:
- Shared package alu_stream_pkg holds:
  - opcode_t enum (OPCODE_ADD, OPCODE_XOR, OPCODE_AND, OPCODE_OR).
  - Header field constants: OPCODE_LSB=0, OPCODE_W=2.
  - The state enum for this block.
- The upstream ALU stage is refactored to import the same opcode_t.
- Single module; no sub-module needed.

Test Plan:
- Basic packet: sop hdr 0x1 (XOR), data 0x5, 0x7, 0x10 with eop, src_ready=1 → header 0x0003_0001 (sop=1), then sum 0x0000_001C (eop=1). err_count=0.
- Wrap and backpressure: opcode 0, data 0xFFFF_FFFF, 0x2 with eop; src_ready low for 5 cycles → snk_ready=0 and header held stable throughout. Then 0x0002_0000 followed by sum 0x0000_0001.
- Header-only packet: sop&eop beat with data 0x3 → 0x0000_0003 then 0x0000_0000.
- Framing errors:
  - Data beat 0xAA with no sop in IDLE → dropped, err_count=1.
  - sop(op 2), 0x4, then sop(op 1), 0x6 with eop → only 0x0001_0001 and 0x0000_0006 emitted, err_count=2.
- Reset mid-packet: sop, 0x9, rst for 1 cycle, then a clean packet (op 0, 0x1 eop) → only 0x0001_0000 and 0x0000_0001 emitted. err_count=0 after reset.
- Bubbles and count saturation (CNT_W=4): 20 data beats of 0x1 with random snk_valid gaps → header count field 0xF, sum 0x14.

Source files
------------

// File: rtl/alu_stream_pkg.sv
// Shared types for the opcode ALU stream: opcode encoding, header field
// placement and the result reducer state encoding.
// Imported by the ALU stage and by result_reducer.
package alu_stream_pkg;

  typedef enum logic [1:0] {
    OPCODE_ADD = 2'd0,
    OPCODE_XOR = 2'd1,
    OPCODE_AND = 2'd2,
    OPCODE_OR  = 2'd3
  } opcode_t;

  // Opcode position inside a header word.
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EMIT_HDR,
    ST_EMIT_SUM
  } rr_state_t;

endpackage

// File: rtl/result_reducer_if.sv
// Avalon-ST link (ready_latency = 0): sop/eop/valid/data forward, ready back.
// No logic; the master drives the forward signals, the slave drives ready.
// One instance per direction of a stream hop.
interface result_reducer_if #(
  parameter int DATA_W = 32
);
  logic              sop;
  logic              eop;
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output sop, output eop, output valid, output data, input ready);
  modport slave  (input sop, input eop, input valid, input data, output ready);
endinterface

// File: rtl/result_reducer.sv
// Reduces each ALU result packet to {header(count, opcode), 32-bit wrapping sum}.
// Latency: header valid the cycle after eop is accepted, sum the cycle after header transfer.
// Backpressure: snk.ready is low while a summary is pending; it never depends on src.ready.
module result_reducer
  import alu_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,  // must be <= DATA_W-2 so count and opcode fields never overlap
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  result_reducer_if.slave  snk,
  result_reducer_if.master src,
  output logic [ERR_W-1:0] err_count
);

  rr_state_t         state_q, state_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  opcode_t           op_q, op_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              err_inc;
  logic              src_vld_q, src_vld_d;
  logic              src_sop_q, src_sop_d;
  logic              src_eop_q, src_eop_d;
  logic [DATA_W-1:0] src_dat_q, src_dat_d;
  logic              snk_rdy;
  logic              snk_acc;

  // Ready is a pure state decode, forced low during reset.
  assign snk_rdy = !rst && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
  assign snk_acc = snk.valid && snk_rdy;

  assign snk.ready = snk_rdy;
  assign src.valid = src_vld_q;
  assign src.sop   = src_sop_q;
  assign src.eop   = src_eop_q;
  assign src.data  = src_dat_q;
  assign err_count = err_q;

  // Next state, accumulators, error counting and registered-output preload.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    err_inc   = 1'b0;
    src_vld_d = 1'b0;
    src_sop_d = 1'b0;
    src_eop_d = 1'b0;
    src_dat_d = '0;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (snk_acc) begin
          if (snk.sop) begin
            // A sop inside a packet means the previous eop went missing:
            // drop the partial packet and restart from this header.
            err_inc = (state_q == ST_ACCUM);
            op_d    = opcode_t'(snk.data[OPCODE_LSB +: OPCODE_W]);
            sum_d   = '0;
            cnt_d   = '0;
            state_d = snk.eop ? ST_EMIT_HDR : ST_ACCUM;
          end else if (state_q == ST_IDLE) begin
            err_inc = 1'b1;  // data beat with no header: dropped
          end else begin
            sum_d = sum_q + snk.data;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (snk.eop) begin
              state_d = ST_EMIT_HDR;
            end
          end
        end
      end
      ST_EMIT_HDR: if (src.ready) state_d = ST_EMIT_SUM;
      ST_EMIT_SUM: if (src.ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    err_d = (err_inc && !(&err_q)) ? err_q + 1'b1 : err_q;

    // Outputs are a function of the next state so they leave the flops
    // already aligned with it; sum/count/opcode are frozen while emitting.
    case (state_d)
      ST_EMIT_HDR: begin
        src_vld_d = 1'b1;
        src_sop_d = 1'b1;
        src_dat_d[DATA_W-1 -: CNT_W]        = cnt_d;
        src_dat_d[OPCODE_LSB +: OPCODE_W]   = op_d;
      end
      ST_EMIT_SUM: begin
        src_vld_d = 1'b1;
        src_eop_d = 1'b1;
        src_dat_d = sum_d;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sum_q     <= '0;
      cnt_q     <= '0;
      op_q      <= OPCODE_ADD;
      err_q     <= '0;
      src_vld_q <= 1'b0;
      src_sop_q <= 1'b0;
      src_eop_q <= 1'b0;
      src_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      err_q     <= err_d;
      src_vld_q <= src_vld_d;
      src_sop_q <= src_sop_d;
      src_eop_q <= src_eop_d;
      src_dat_q <= src_dat_d;
    end
  end

endmodule

// File: tb/tb_result_reducer.sv
// Bench for result_reducer: two instances (count width 16 and 4) fed the same
// sink stream and source ready; a packet-level model predicts every output
// word, ready and error count, and scenarios pin literal summaries.
module tb_result_reducer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic src_rdy = 1'b1;
  bit   rnd_rdy = 1'b0;
  logic [7:0] a_err, b_err;

  always #5 clk = ~clk;

  result_reducer_if #(.DATA_W(32)) a_snk ();
  result_reducer_if #(.DATA_W(32)) a_src ();
  result_reducer_if #(.DATA_W(32)) b_snk ();
  result_reducer_if #(.DATA_W(32)) b_src ();

  assign b_snk.sop   = a_snk.sop;
  assign b_snk.eop   = a_snk.eop;
  assign b_snk.valid = a_snk.valid;
  assign b_snk.data  = a_snk.data;
  assign a_src.ready = src_rdy;
  assign b_src.ready = src_rdy;

  result_reducer #(.DATA_W(32), .CNT_W(16), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .snk(a_snk), .src(a_src), .err_count(a_err));
  result_reducer #(.DATA_W(32), .CNT_W(4), .ERR_W(8)) dut_b (
    .clk(clk), .rst(rst), .snk(b_snk), .src(b_src), .err_count(b_err));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each queue holds the summary words still owed by that instance:
  // two entries = header pending, one entry = sum pending.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          m_inpkt;
  logic [1:0]  m_op;
  logic [31:0] m_sum;
  int          m_cnt;
  int          m_err;

  function automatic void m_bad();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void m_close();
    int ca, cb;
    ca = (m_cnt > 65535) ? 65535 : m_cnt;
    cb = (m_cnt > 15) ? 15 : m_cnt;
    qa.push_back((32'(ca) << 16) | 32'(m_op));
    qa.push_back(m_sum);
    qb.push_back((32'(cb) << 28) | 32'(m_op));
    qb.push_back(m_sum);
    m_inpkt = 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete();
      m_inpkt = 0; m_err = 0; m_sum = 0; m_cnt = 0; m_op = 0;
    end else if (qa.size() != 0) begin
      if (src_rdy) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
    end else if (a_snk.valid) begin
      if (a_snk.sop) begin
        if (m_inpkt) m_bad();
        m_op = a_snk.data[1:0]; m_sum = 0; m_cnt = 0; m_inpkt = 1;
        if (a_snk.eop) m_close();
      end else if (!m_inpkt) begin
        m_bad();
      end else begin
        m_sum = m_sum + a_snk.data;
        m_cnt++;
        if (a_snk.eop) m_close();
      end
    end
  end

  // ---------------- compare + capture ----------------
  logic [31:0] cap_a[$];
  logic [31:0] cap_b[$];

  always @(negedge clk) begin
    chk("a_src_valid", a_src.valid, qa.size() != 0);
    chk("b_src_valid", b_src.valid, qb.size() != 0);
    if (qa.size() != 0) begin
      chk("a_src_data", a_src.data, qa[0]);
      chk("a_src_sop", a_src.sop, qa.size() == 2);
      chk("a_src_eop", a_src.eop, qa.size() == 1);
    end
    if (qb.size() != 0) begin
      chk("b_src_data", b_src.data, qb[0]);
      chk("b_src_sop", b_src.sop, qb.size() == 2);
      chk("b_src_eop", b_src.eop, qb.size() == 1);
    end
    chk("a_snk_ready", a_snk.ready, !rst && qa.size() == 0);
    chk("b_snk_ready", b_snk.ready, !rst && qb.size() == 0);
    chk("a_err_count", a_err, m_err);
    chk("b_err_count", b_err, m_err);
    if (!rst && src_rdy) begin
      if (a_src.valid) cap_a.push_back(a_src.data);
      if (b_src.valid) cap_b.push_back(b_src.data);
    end
  end

  // Random source backpressure when enabled.
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      src_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- drivers ----------------
  // Invariant: tasks start and end 1 time unit after a rising edge.
  task automatic send(input bit s, input bit e, input logic [31:0] d, input int gap_max);
    int  g;
    bit  acc;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) begin @(posedge clk); #1; end
    a_snk.sop = s; a_snk.eop = e; a_snk.data = d; a_snk.valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = a_snk.ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: beat %h not accepted, expected acceptance", d);
    end
    a_snk.valid = 1'b0; a_snk.sop = 1'b0; a_snk.eop = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (qa.size() == 0) && a_snk.ready;
    end
    @(posedge clk); #1;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: summary still pending, expected idle");
    end
  endtask

  task automatic chk_cap(input string nm, input logic [31:0] ea0, input logic [31:0] ea1,
                         input logic [31:0] eb0, input logic [31:0] eb1);
    chk({nm, "_a_words"}, cap_a.size(), 2);
    chk({nm, "_b_words"}, cap_b.size(), 2);
    if (cap_a.size() == 2) begin
      chk({nm, "_a_hdr"}, cap_a[0], ea0);
      chk({nm, "_a_sum"}, cap_a[1], ea1);
    end
    if (cap_b.size() == 2) begin
      chk({nm, "_b_hdr"}, cap_b[0], eb0);
      chk({nm, "_b_sum"}, cap_b[1], eb1);
    end
    cap_a.delete(); cap_b.delete();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    a_snk.sop = 0; a_snk.eop = 0; a_snk.valid = 0; a_snk.data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_src_valid", a_src.valid, 0);
    chk("rst_src_data", a_src.data, 0);
    chk("rst_err", a_err, 0);
    chk("rst_snk_ready", a_snk.ready, 0);
    rst = 0;
    @(posedge clk); #1;
    cap_a.delete(); cap_b.delete();

    // Basic XOR packet.
    send(1, 0, 32'h1, 0); send(0, 0, 32'h5, 0); send(0, 0, 32'h7, 0); send(0, 1, 32'h10, 0);
    drain();
    chk_cap("basic", 32'h0003_0001, 32'h0000_001C, 32'h3000_0001, 32'h0000_001C);
    chk("basic_err", a_err, 0);

    // Wrap-around sum under a 5-cycle source stall.
    src_rdy = 0;
    send(1, 0, 32'h0, 0); send(0, 0, 32'hFFFF_FFFF, 0); send(0, 1, 32'h2, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_snk_ready", a_snk.ready, 0);
      chk("stall_hdr", a_src.data, 32'h0002_0000);
      chk("stall_sop", a_src.sop, 1);
    end
    src_rdy = 1;
    @(posedge clk); #1;
    drain();
    chk_cap("wrap", 32'h0002_0000, 32'h0000_0001, 32'h2000_0000, 32'h0000_0001);

    // Header-only packet.
    send(1, 1, 32'h3, 0);
    drain();
    chk_cap("hdr_only", 32'h0000_0003, 32'h0, 32'h0000_0003, 32'h0);

    // Framing errors: stray beat, then missing eop.
    send(0, 0, 32'hAA, 0);
    @(negedge clk); chk("stray_err", a_err, 1);
    @(posedge clk); #1;
    chk("stray_no_out", cap_a.size(), 0);
    send(1, 0, 32'h2, 0); send(0, 0, 32'h4, 0); send(1, 0, 32'h1, 0); send(0, 1, 32'h6, 0);
    drain();
    chk_cap("restart", 32'h0001_0001, 32'h0000_0006, 32'h1000_0001, 32'h0000_0006);
    chk("restart_err", a_err, 2);

    // Reset mid-packet.
    send(1, 0, 32'h0, 0); send(0, 0, 32'h9, 0);
    rst = 1; @(posedge clk); #1; rst = 0;
    chk("midrst_err", a_err, 0);
    send(1, 0, 32'h0, 0); send(0, 1, 32'h1, 0);
    drain();
    chk_cap("midrst", 32'h0001_0000, 32'h0000_0001, 32'h1000_0000, 32'h0000_0001);

    // Count saturation (narrow instance) with bubbles.
    send(1, 0, 32'h3, 2);
    for (int i = 0; i < 20; i++) send(0, i == 19, 32'h1, 3);
    drain();
    chk_cap("sat", 32'h0014_0003, 32'h0000_0014, 32'hF000_0003, 32'h0000_0014);

    // Random traffic with random framing faults and backpressure.
    rnd_rdy = 1;
    for (int p = 0; p < 40; p++) begin
      int kind, nb;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send(0, $urandom_range(0, 1), $urandom, 2);
      end else begin
        nb = $urandom_range(0, 5);
        send(1, nb == 0, $urandom, 2);
        for (int b = 0; b < nb; b++) begin
          bit last;
          last = (b == nb - 1) && (kind != 1);
          send(0, last, $urandom, 2);
        end
      end
    end
    send(1, 0, 32'h2, 0); send(0, 1, $urandom, 0);
    drain();
    rnd_rdy = 0;
    @(posedge clk); #1;
    src_rdy = 1;
    drain();

    // Error counter saturation.
    for (int i = 0; i < 260; i++) send(0, 0, 32'(i), 0);
    @(negedge clk);
    chk("err_sat", a_err, 8'hFF);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
